// File: rtl/csp_pkg.sv
// Shared constants and helpers for the round-robin write arbiter.
package csp_pkg;

  localparam int unsigned CSP_DATA_WIDTH = 32;
  localparam int unsigned CSP_MAX_PORTS  = 16;
  localparam int unsigned CSP_STAT_WIDTH = 32;

  // Ceil-log2 with a floor of 1 so a pointer always has at least one bit.
  function automatic int unsigned csp_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_write_arbiter_if.sv
// Producer-side ap_fifo write ports plus the shared downstream FIFO write port.
interface rr_write_arbiter_if
  import csp_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = CSP_DATA_WIDTH
);

  logic [NUM_PORTS*DATA_WIDTH-1:0] p_write_data;
  logic [NUM_PORTS-1:0]            p_write_request;
  logic [NUM_PORTS-1:0]            p_write_valid;
  logic [DATA_WIDTH-1:0]           channel_write_data;
  logic                            channel_write_request;
  logic                            channel_write_valid;

  // Arbiter view.
  modport master (
    input  p_write_data, p_write_request, channel_write_valid,
    output p_write_valid, channel_write_data, channel_write_request
  );

  // Environment view: producers and FIFO.
  modport slave (
    output p_write_data, p_write_request, channel_write_valid,
    input  p_write_valid, channel_write_data, channel_write_request
  );

endinterface

// File: rtl/rr_grant_select.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping mod NUM_PORTS.
module rr_grant_select
  import csp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned PW       = csp_clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PW-1:0]        ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PW-1:0]        gnt_idx_o,
  output logic                 any_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Explicit subtract keeps non-power-of-2 port counts from indexing past the last port.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
      idx = PW'(sum);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_write_arbiter.sv
// N-way round-robin merge of ap_fifo producers onto one FIFO write port, one holding slot per port.
// Optional per-port grant and stall counters enabled by defining CSP_ARB_STATS_EN.
module rr_write_arbiter
  import csp_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = CSP_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  rr_write_arbiter_if.master bus
`ifdef CSP_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CSP_STAT_WIDTH-1:0] stat_grant_count,
  output logic [CSP_STAT_WIDTH-1:0]           stat_stall_count
`endif
);

  localparam int unsigned PW = csp_clog2(NUM_PORTS);

  typedef logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] slot_arr_t;

  logic [NUM_PORTS-1:0] occ_q, occ_d;
  slot_arr_t            slot_q, slot_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

  slot_arr_t            p_data_c;
  logic [NUM_PORTS-1:0] cap_c;
  logic [NUM_PORTS-1:0] gnt_c;
  logic [PW-1:0]        gnt_idx_c;
  logic                 any_occ_c;
  logic                 issue_c;
  logic [PW-1:0]        cap_idx;

  assign p_data_c = bus.p_write_data;
  // A request while the slot is occupied is a protocol error and is dropped here.
  assign cap_c    = bus.p_write_request & ~occ_q;
  assign issue_c  = any_occ_c & bus.channel_write_valid;

  rr_grant_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_grant_select (
    .req_i     (occ_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_c),
    .gnt_idx_o (gnt_idx_c),
    .any_o     (any_occ_c)
  );

  // Slot, occupancy and pointer next-state.
  always_comb begin
    slot_d   = slot_q;
    occ_d    = (occ_q & ~(issue_c ? gnt_c : '0)) | cap_c;
    rr_ptr_d = rr_ptr_q;
    cap_idx  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cap_idx = PW'(k);
      if (cap_c[cap_idx]) slot_d[cap_idx] = p_data_c[cap_idx];
    end
    if (issue_c) begin
      rr_ptr_d = (gnt_idx_c == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx_c + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q    <= '0;
      slot_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      slot_q   <= slot_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.p_write_valid         = ~occ_q;
  assign bus.channel_write_request = issue_c;
  assign bus.channel_write_data    = issue_c ? slot_q[gnt_idx_c] : '0;

`ifdef CSP_ARB_STATS_EN
  localparam logic [CSP_STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [NUM_PORTS-1:0][CSP_STAT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
  logic [CSP_STAT_WIDTH-1:0]                stall_cnt_q, stall_cnt_d;

  // Saturating observers; they only watch the datapath.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue_c && (grant_cnt_q[gnt_idx_c] != STAT_MAX)) begin
      grant_cnt_d[gnt_idx_c] = grant_cnt_q[gnt_idx_c] + CSP_STAT_WIDTH'(1);
    end
    if (any_occ_c && !bus.channel_write_valid && (stall_cnt_q != STAT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CSP_STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_grant_count = grant_cnt_q;
  assign stat_stall_count = stall_cnt_q;
`endif

endmodule
